// File: rtl/clock_pkg.sv
// Shared encodings, limits and field helpers for the multi-alarm clock core.
// The SNOOZE alarm state exists only when MULTI_ALARM_SNOOZE_EN is defined.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_CLOCK     = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      POS_SEC  = 2'd0,
      POS_MIN  = 2'd1,
      POS_HOUR = 2'd2
   } pos_e;

   typedef enum logic [1:0] {
      AL_IDLE    = 2'd0,
`ifdef MULTI_ALARM_SNOOZE_EN
      AL_SNOOZE  = 2'd2,
`endif
      AL_RINGING = 2'd1
   } alarm_state_e;

   localparam logic [5:0] HOUR_MAX = 6'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] SEC_MAX  = 6'd59;

   typedef struct packed {
      logic [5:0] hour;
      logic [5:0] minute;
      logic [5:0] second;
   } hms_t;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
      return (v >= max) ? 6'd0 : v + 6'd1;
   endfunction

   // Single-field edit: wraps within the field, never carries into the next one.
   function automatic hms_t edit_field(input hms_t t, input pos_e p);
      hms_t res;
      res = t;
      case (p)
         POS_SEC: res.second = wrap_inc(t.second, SEC_MAX);
         POS_MIN: res.minute = wrap_inc(t.minute, MIN_MAX);
         default: res.hour   = wrap_inc(t.hour, HOUR_MAX);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1 and flags the terminal count for one cycle.
module clock_tick_gen #(
   parameter  int CLK_HZ = 50_000_000,
   localparam int CNT_W  = $clog2(CLK_HZ)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   output logic o_tick
);

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == CNT_W'(CLK_HZ - 1));

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multi_alarm_clock_core.sv
// Timekeeping, set-mode FSM, NUM_ALARMS alarm slots and ring FSM.
// Define MULTI_ALARM_SNOOZE_EN to build in the SNOOZE state and its timer.
module multi_alarm_clock_core
   import clock_pkg::*;
#(
   parameter  int CLK_HZ        = 50_000_000,
   parameter  int NUM_ALARMS    = 4,
   parameter  int ALARM_DUR_SEC = 60,
   parameter  int SNOOZE_MIN    = 5,
   localparam int SEL_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_mode,
   input  logic                  i_pos,
   input  logic                  i_inc,
   input  logic                  i_ack,
   input  logic [SEL_W-1:0]      i_alarm_sel,
   input  logic [NUM_ALARMS-1:0] i_alarm_en,
   output logic [5:0]            o_hour,
   output logic [5:0]            o_min,
   output logic [5:0]            o_sec,
   output logic [1:0]            o_mode,
   output logic [1:0]            o_position,
   output logic                  o_tick,
   output logic [NUM_ALARMS-1:0] o_alarm_hit,
   output logic                  o_buzz_en
);

   localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
   localparam int TMR_MAX      = (ALARM_DUR_SEC > SNOOZE_TICKS) ? ALARM_DUR_SEC : SNOOZE_TICKS;
   localparam int TMR_W        = $clog2(TMR_MAX + 1);

   mode_e                 r_mode, w_mode_nxt;
   pos_e                  r_pos, w_pos_nxt;
   hms_t                  r_time, w_time_adv, w_sel_alarm, w_disp;
   hms_t                  r_alarm [NUM_ALARMS];
   logic                  r_tick;
   logic                  w_ps_tick, w_ps_clr, w_adv, w_inc;
   logic                  w_match, w_slot_en;
   logic [NUM_ALARMS-1:0] w_match_hit, r_hit, w_hit_nxt;
   alarm_state_e          r_al_state, w_al_nxt;
   logic [TMR_W-1:0]      r_tmr, w_tmr_nxt;

   // Leaving SET_TIME restarts the second so the edited time begins on a full second.
   assign w_ps_clr = i_mode && (r_mode == MODE_SET_TIME);
   assign w_adv    = w_ps_tick && (r_mode != MODE_SET_TIME);
   assign w_inc    = i_inc && !i_mode && !i_pos;

   clock_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_ps_clr),
      .o_tick  (w_ps_tick)
   );

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      w_mode_nxt = r_mode;
      w_pos_nxt  = r_pos;
      if (i_mode) begin
         case (r_mode)
            MODE_CLOCK:    w_mode_nxt = MODE_SET_TIME;
            MODE_SET_TIME: w_mode_nxt = MODE_SET_ALARM;
            default:       w_mode_nxt = MODE_CLOCK;
         endcase
         w_pos_nxt = POS_SEC;
      end else if (i_pos && (r_mode != MODE_CLOCK)) begin
         case (r_pos)
            POS_SEC: w_pos_nxt = POS_MIN;
            POS_MIN: w_pos_nxt = POS_HOUR;
            default: w_pos_nxt = POS_SEC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_CLOCK;
         r_pos  <= POS_SEC;
      end else begin
         r_mode <= w_mode_nxt;
         r_pos  <= w_pos_nxt;
      end
   end

   always_comb begin
      w_time_adv        = r_time;
      w_time_adv.second = wrap_inc(r_time.second, SEC_MAX);
      if (r_time.second == SEC_MAX) begin
         w_time_adv.minute = wrap_inc(r_time.minute, MIN_MAX);
         if (r_time.minute == MIN_MAX) begin
            w_time_adv.hour = wrap_inc(r_time.hour, HOUR_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_time <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_adv;
         if (w_adv) begin
            r_time <= w_time_adv;
         end else if (w_inc && (r_mode == MODE_SET_TIME)) begin
            r_time <= edit_field(r_time, r_pos);
         end
      end
   end

   // NOTE: the alarm array is reset on purpose; every slot must read 00:00:00 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ALARMS; i++) r_alarm[i] <= '0;
      end else if (w_inc && (r_mode == MODE_SET_ALARM)) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (i == int'(i_alarm_sel)) r_alarm[i] <= edit_field(r_alarm[i], r_pos);
         end
      end
   end

   always_comb begin
      w_sel_alarm = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (i == int'(i_alarm_sel)) w_sel_alarm = r_alarm[i];
      end
   end

   assign w_disp = (r_mode == MODE_SET_ALARM) ? w_sel_alarm : r_time;

   // Scanning downwards leaves the lowest matching slot as the winner.
   always_comb begin
      w_match     = 1'b0;
      w_match_hit = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (i_alarm_en[i] && (r_alarm[i] == r_time)) begin
            w_match        = 1'b1;
            w_match_hit    = '0;
            w_match_hit[i] = 1'b1;
         end
      end
   end

   assign w_slot_en = |(i_alarm_en & r_hit);

   // r_tick marks a genuine advance, so edits alone can never start a ring.
   always_comb begin
      w_al_nxt  = r_al_state;
      w_hit_nxt = r_hit;
      w_tmr_nxt = r_tmr;
      case (r_al_state)
         AL_IDLE: begin
            if (r_tick && w_match) begin
               w_al_nxt  = AL_RINGING;
               w_hit_nxt = w_match_hit;
               w_tmr_nxt = '0;
            end
         end
         AL_RINGING: begin
            if (!w_slot_en) begin
               w_al_nxt = AL_IDLE;
            end else if (i_ack) begin
`ifdef MULTI_ALARM_SNOOZE_EN
               w_al_nxt  = AL_SNOOZE;
               w_tmr_nxt = '0;
`else
               w_al_nxt  = AL_IDLE;
`endif
            end else if (r_tick) begin
               if (r_tmr == TMR_W'(ALARM_DUR_SEC - 1)) w_al_nxt = AL_IDLE;
               else                                     w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
`ifdef MULTI_ALARM_SNOOZE_EN
         AL_SNOOZE: begin
            if (!w_slot_en || i_ack) begin
               w_al_nxt = AL_IDLE;
            end else if (r_tick) begin
               if (r_tmr == TMR_W'(SNOOZE_TICKS - 1)) begin
                  w_al_nxt  = AL_RINGING;
                  w_tmr_nxt = '0;
               end else begin
                  w_tmr_nxt = r_tmr + TMR_W'(1);
               end
            end
         end
`endif
         default: w_al_nxt = AL_IDLE;
      endcase
      if (w_al_nxt == AL_IDLE) w_hit_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_al_state <= AL_IDLE;
         r_hit      <= '0;
         r_tmr      <= '0;
      end else begin
         r_al_state <= w_al_nxt;
         r_hit      <= w_hit_nxt;
         r_tmr      <= w_tmr_nxt;
      end
   end

   assign o_hour      = w_disp.hour;
   assign o_min       = w_disp.minute;
   assign o_sec       = w_disp.second;
   assign o_mode      = r_mode;
   assign o_position  = r_pos;
   assign o_tick      = r_tick;
   assign o_alarm_hit = r_hit;
   assign o_buzz_en   = (r_al_state == AL_RINGING);

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed bench for multi_alarm_clock_core with CLK_HZ=4, ALARM_DUR_SEC=3, SNOOZE_MIN=1.
// Inputs change and outputs are sampled on the falling edge.
module tb_multi_alarm_clock_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_mode = 1'b0, i_pos = 1'b0, i_inc = 1'b0, i_ack = 1'b0;
   logic [1:0] i_alarm_sel = '0;
   logic [3:0] i_alarm_en = '0;
   logic [5:0] o_hour, o_min, o_sec;
   logic [1:0] o_mode, o_position;
   logic       o_tick, o_buzz_en;
   logic [3:0] o_alarm_hit;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_alarm_clock_core #(
      .CLK_HZ(4), .NUM_ALARMS(4), .ALARM_DUR_SEC(3), .SNOOZE_MIN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_pos(i_pos), .i_inc(i_inc), .i_ack(i_ack),
      .i_alarm_sel(i_alarm_sel), .i_alarm_en(i_alarm_en),
      .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec), .o_mode(o_mode), .o_position(o_position),
      .o_tick(o_tick), .o_alarm_hit(o_alarm_hit), .o_buzz_en(o_buzz_en)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic m, input logic p, input logic inc, input logic ack);
      i_mode = m; i_pos = p; i_inc = inc; i_ack = ack;
      @(negedge clk);
      i_mode = 1'b0; i_pos = 1'b0; i_inc = 1'b0; i_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Stops on the sample where the tick showing the target second is visible.
   task automatic wait_sec(input logic [5:0] target, input int budget, input string name);
      int cyc = 0;
      while (!(o_tick && o_sec == target) && cyc < budget) begin
         step(1);
         cyc++;
      end
      n_cmp++;
      if (!(o_tick && o_sec == target)) begin
         n_err++;
         $display("FAIL %s: timeout, sec=%0d expected %0d", name, o_sec, target);
      end
   endtask

   // Counts ticks starting with the current sample; stops on the n-th.
   task automatic wait_ticks(input int n, input int budget, input string name);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < budget) begin
         if (o_tick) seen++;
         if (seen < n) begin
            step(1);
            cyc++;
         end
      end
      n_cmp++;
      if (seen != n) begin
         n_err++;
         $display("FAIL %s: saw %0d ticks expected %0d", name, seen, n);
      end
   endtask

   task automatic set_alarm(input logic [1:0] slot, input int secs);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      i_alarm_sel = slot;
      repeat (secs) pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
   endtask

   task automatic test_reset();
      int ticks = 0;
      rst_n = 1'b0;
      step(2);
      n_cmp++;
      if ({o_hour, o_min, o_sec, o_mode, o_position, o_tick, o_alarm_hit, o_buzz_en} !== 29'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got h%0d m%0d s%0d mode%0d pos%0d hit%b buzz%b, expected all 0",
                  o_hour, o_min, o_sec, o_mode, o_position, o_alarm_hit, o_buzz_en);
      end
      rst_n = 1'b1;
      repeat (4) begin
         step(1);
         if (o_tick) ticks++;
      end
      n_cmp++;
      if (ticks != 1) begin n_err++; $display("FAIL first_tick_count: got %0d expected 1", ticks); end
      n_cmp++;
      if (o_sec !== 6'd1) begin n_err++; $display("FAIL first_tick_sec: got %0d expected 1", o_sec); end
   endtask

   task automatic test_preload_wrap();
      do_reset();
      pulse(1, 0, 0, 0);
      n_cmp++;
      if (o_mode !== 2'd1) begin n_err++; $display("FAIL enter_set_time: mode %0d expected 1", o_mode); end
      repeat (59) pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      repeat (59) pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      repeat (23) pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      n_cmp++;
      if ({o_hour, o_min, o_sec, o_mode} !== {6'd23, 6'd59, 6'd59, 2'd0}) begin
         n_err++;
         $display("FAIL preload: got %0d:%0d:%0d mode%0d expected 23:59:59 mode0", o_hour, o_min, o_sec, o_mode);
      end
      wait_ticks(1, 10, "wrap_tick");
      n_cmp++;
      if ({o_hour, o_min, o_sec} !== 18'd0) begin
         n_err++;
         $display("FAIL day_wrap: got %0d:%0d:%0d expected 0:0:0", o_hour, o_min, o_sec);
      end
   endtask

   task automatic test_set_time();
      int ticks = 0;
      do_reset();
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      n_cmp++;
      if (o_position !== 2'd2) begin n_err++; $display("FAIL pos_hour: got %0d expected 2", o_position); end
      repeat (25) begin
         pulse(0, 0, 1, 0);
         if (o_tick) ticks++;
      end
      step(8);
      if (o_tick) ticks++;
      n_cmp++;
      if ({o_hour, o_min, o_sec} !== {6'd1, 6'd0, 6'd0}) begin
         n_err++;
         $display("FAIL hour_inc_wrap: got %0d:%0d:%0d expected 1:0:0", o_hour, o_min, o_sec);
      end
      n_cmp++;
      if (ticks != 0) begin n_err++; $display("FAIL frozen_in_set_time: got %0d ticks expected 0", ticks); end
      pulse(0, 1, 1, 0);
      n_cmp++;
      if ({o_position, o_hour, o_sec} !== {2'd0, 6'd1, 6'd0}) begin
         n_err++;
         $display("FAIL pos_beats_inc: pos%0d h%0d s%0d expected pos0 h1 s0", o_position, o_hour, o_sec);
      end
      pulse(1, 0, 1, 0);
      n_cmp++;
      if ({o_mode, o_position, o_hour, o_sec} !== {2'd2, 2'd0, 6'd0, 6'd0}) begin
         n_err++;
         $display("FAIL mode_beats_inc: mode%0d pos%0d alarm h%0d s%0d expected mode2 pos0 0 0",
                  o_mode, o_position, o_hour, o_sec);
      end
      pulse(1, 0, 0, 0);
      n_cmp++;
      if ({o_mode, o_hour, o_min} !== {2'd0, 6'd1, 6'd0}) begin
         n_err++;
         $display("FAIL time_after_edit: mode%0d %0d:%0d expected mode0 1:0", o_mode, o_hour, o_min);
      end
      pulse(0, 1, 0, 0);
      n_cmp++;
      if (o_position !== 2'd0) begin n_err++; $display("FAIL pos_ignored_clock: got %0d expected 0", o_position); end
   endtask

   task automatic test_alarm_ring();
      do_reset();
      i_alarm_en = 4'b0010;
      set_alarm(2'd1, 5);
      wait_sec(6'd5, 100, "ring_wait");
      n_cmp++;
      if (o_buzz_en !== 1'b0) begin n_err++; $display("FAIL ring_latency_early: buzz %b expected 0", o_buzz_en); end
      step(1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b1_0010) begin
         n_err++;
         $display("FAIL ring_start: buzz %b hit %b expected 1 0010", o_buzz_en, o_alarm_hit);
      end
      wait_ticks(3, 40, "ring_dur_ticks");
      n_cmp++;
      if ({o_buzz_en, o_sec} !== {1'b1, 6'd8}) begin
         n_err++;
         $display("FAIL ring_third_tick: buzz %b sec %0d expected 1 8", o_buzz_en, o_sec);
      end
      step(1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0000) begin
         n_err++;
         $display("FAIL ring_auto_stop: buzz %b hit %b expected 0 0000", o_buzz_en, o_alarm_hit);
      end
   endtask

   task automatic test_priority();
      do_reset();
      i_alarm_en = 4'b0101;
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      i_alarm_sel = 2'd0;
      repeat (2) pulse(0, 0, 1, 0);
      i_alarm_sel = 2'd2;
      repeat (2) pulse(0, 0, 1, 0);
      n_cmp++;
      if (o_sec !== 6'd2) begin n_err++; $display("FAIL alarm2_display: got %0d expected 2", o_sec); end
      pulse(1, 0, 0, 0);
      wait_sec(6'd2, 60, "prio_wait");
      step(1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b1_0001) begin
         n_err++;
         $display("FAIL lowest_slot_wins: buzz %b hit %b expected 1 0001", o_buzz_en, o_alarm_hit);
      end
      i_alarm_en = 4'b0100;
      step(1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0000) begin
         n_err++;
         $display("FAIL enable_clear_stops: buzz %b hit %b expected 0 0000", o_buzz_en, o_alarm_hit);
      end
   endtask

   task automatic test_ack();
      do_reset();
      i_alarm_en = 4'b0010;
      set_alarm(2'd1, 3);
      wait_sec(6'd3, 60, "ack_wait");
      step(1);
      n_cmp++;
      if (o_buzz_en !== 1'b1) begin n_err++; $display("FAIL ack_ring_start: buzz %b expected 1", o_buzz_en); end
      pulse(0, 0, 0, 1);
`ifdef MULTI_ALARM_SNOOZE_EN
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0010) begin
         n_err++;
         $display("FAIL snooze_enter: buzz %b hit %b expected 0 0010", o_buzz_en, o_alarm_hit);
      end
      wait_ticks(60, 400, "snooze_ticks");
      n_cmp++;
      if (o_buzz_en !== 1'b0) begin n_err++; $display("FAIL snooze_hold: buzz %b expected 0", o_buzz_en); end
      step(1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b1_0010) begin
         n_err++;
         $display("FAIL snooze_rering: buzz %b hit %b expected 1 0010", o_buzz_en, o_alarm_hit);
      end
      pulse(0, 0, 0, 1);
      pulse(0, 0, 0, 1);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0000) begin
         n_err++;
         $display("FAIL snooze_ack_idle: buzz %b hit %b expected 0 0000", o_buzz_en, o_alarm_hit);
      end
`else
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0000) begin
         n_err++;
         $display("FAIL ack_idle: buzz %b hit %b expected 0 0000", o_buzz_en, o_alarm_hit);
      end
      step(12);
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit} !== 5'b0_0000) begin
         n_err++;
         $display("FAIL ack_stays_idle: buzz %b hit %b expected 0 0000", o_buzz_en, o_alarm_hit);
      end
`endif
   endtask

   task automatic test_reset_mid_ring();
      int rang = 0;
      do_reset();
      i_alarm_en = 4'b0010;
      set_alarm(2'd1, 3);
      wait_sec(6'd3, 60, "midring_wait");
      step(1);
      n_cmp++;
      if (o_buzz_en !== 1'b1) begin n_err++; $display("FAIL midring_start: buzz %b expected 1", o_buzz_en); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_buzz_en, o_alarm_hit, o_hour, o_min, o_sec} !== 23'd0) begin
         n_err++;
         $display("FAIL async_reset: buzz %b hit %b time %0d:%0d:%0d expected all 0",
                  o_buzz_en, o_alarm_hit, o_hour, o_min, o_sec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
         step(1);
         if (o_buzz_en) rang++;
      end
      n_cmp++;
      if (rang != 0) begin n_err++; $display("FAIL no_ring_after_reset: buzz high %0d cycles expected 0", rang); end
      n_cmp++;
      if (o_sec !== 6'd10) begin n_err++; $display("FAIL run_after_reset: sec %0d expected 10", o_sec); end
   endtask

   initial begin
      test_reset();
      test_preload_wrap();
      test_set_time();
      test_alarm_ring();
      test_priority();
      test_ack();
      test_reset_mid_ring();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
